// File: rtl/axis_to_riffa_tx.sv
// axis_to_riffa_tx: collects one AXI4-Stream image frame (one pixel per beat)
// into an external simple-dual-port BRAM as packed PCIe-width words, then
// streams the frame back to the host as a single RIFFA TX transaction.
// Optional build macro AXIS2RIFFA_HEADER_EN prepends a {cols, rows} header word.
module axis_to_riffa_tx #(
  parameter int PCIE_DATA_WIDTH = 128,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int BRAM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                rows,
  input  logic [31:0]                cols,
  output logic                       tx_done,
  input  logic [AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  input  logic                       S_AXIS_TUSER,
  input  logic                       S_AXIS_TLAST,
  output logic                       CHNL_TX,
  input  logic                       CHNL_TX_ACK,
  output logic                       CHNL_TX_LAST,
  output logic [31:0]                CHNL_TX_LEN,
  output logic [30:0]                CHNL_TX_OFF,
  output logic [PCIE_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                       CHNL_TX_DATA_VALID,
  input  logic                       CHNL_TX_DATA_READY,
  output logic [BRAM_ADDR_WIDTH-1:0] addra,
  output logic                       clka,
  output logic [PCIE_DATA_WIDTH-1:0] dina,
  output logic                       wea,
  output logic [BRAM_ADDR_WIDTH-1:0] addrb,
  output logic                       clkb,
  input  logic [PCIE_DATA_WIDTH-1:0] doutb,
  output logic                       enb
);

  localparam int PPW    = PCIE_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WPB    = PCIE_DATA_WIDTH / 32;
`ifdef AXIS2RIFFA_HEADER_EN
  localparam logic [31:0] HDR = 32'd1;
`else
  localparam logic [31:0] HDR = 32'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FLUSH, S_REQ, S_PREP, S_SEND
  } state_t;

  state_t                       state, state_nxt;
  logic                         rdy_ok;
  logic [31:0]                  rows_r, cols_r, n_r;
  logic [31:0]                  pix_cnt, wcnt, sidx;
  logic [SLOT_W-1:0]            slot;
  logic [PCIE_DATA_WIDTH-1:0]   pack_r, dina_r, word_nxt, hdr_word;
  logic                         wea_r;
  logic [BRAM_ADDR_WIDTH-1:0]   addra_r, rd_ptr;
  logic [31:0]                  n_in, len_words, last_idx;
  logic                         accept, start, take, last_pix, slot_full;
  logic                         tx_active, fire, is_hdr;

  assign n_in      = rows * cols;
  assign accept    = S_AXIS_TVALID & S_AXIS_TREADY;
  assign start     = (state == S_IDLE) & accept & S_AXIS_TUSER & (n_in != 32'd0);
  assign take      = start | ((state == S_COLLECT) & accept);
  assign last_pix  = (state == S_IDLE) ? (n_in == 32'd1) : (pix_cnt == n_r - 32'd1);
  assign slot_full = (slot == SLOT_W'(PPW - 1));

  // The final word's write may still be in flight on the first REQ cycle.
  assign len_words = wcnt + {31'b0, wea_r} + HDR;
  assign last_idx  = len_words - 32'd1;
  assign tx_active = (state == S_REQ) | (state == S_PREP) | (state == S_SEND);
  assign fire      = (state == S_SEND) & CHNL_TX_DATA_READY;

`ifdef AXIS2RIFFA_HEADER_EN
  assign is_hdr = (sidx == 32'd0);
  // Header word: rows in the low 32 bits, cols above, zero pad on top.
  always_comb begin
    hdr_word        = '0;
    hdr_word[63:0]  = {cols_r, rows_r};
  end
  logic unused_ok;
  assign unused_ok = S_AXIS_TLAST;
`else
  assign is_hdr   = 1'b0;
  assign hdr_word = '0;
  logic unused_ok;
  assign unused_ok = ^{S_AXIS_TLAST, rows_r, cols_r};
`endif

  // Drop the incoming pixel into its little-endian slot; a new frame starts from zero.
  always_comb begin
    word_nxt = (state == S_IDLE) ? '0 : pack_r;
    word_nxt[slot*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = S_AXIS_TDATA;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = last_pix ? (slot_full ? S_REQ : S_FLUSH) : S_COLLECT;
      S_COLLECT: if (take && last_pix) state_nxt = slot_full ? S_REQ : S_FLUSH;
      S_FLUSH:   state_nxt = S_REQ;
      S_REQ:     if (CHNL_TX_ACK) state_nxt = S_PREP;
      S_PREP:    state_nxt = S_SEND;
      S_SEND:    if (fire && sidx == last_idx) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: pixel packing, BRAM write port, read pointer and word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_ok  <= 1'b0;
      rows_r  <= '0;
      cols_r  <= '0;
      n_r     <= '0;
      pix_cnt <= '0;
      wcnt    <= '0;
      sidx    <= '0;
      slot    <= '0;
      pack_r  <= '0;
      dina_r  <= '0;
      wea_r   <= 1'b0;
      addra_r <= '0;
      rd_ptr  <= '0;
    end else begin
      rdy_ok <= 1'b1;
      wea_r  <= 1'b0;
      if (wea_r) begin
        addra_r <= addra_r + 1'b1;
        wcnt    <= wcnt + 32'd1;
      end
      if (state == S_IDLE) begin
        addra_r <= '0;
        rd_ptr  <= '0;
        wcnt    <= '0;
        sidx    <= '0;
        pix_cnt <= '0;
        slot    <= '0;
        pack_r  <= '0;
      end
      if (start) begin
        rows_r <= rows;
        cols_r <= cols;
        n_r    <= n_in;
      end
      if (take) begin
        pix_cnt <= pix_cnt + 32'd1;
        slot    <= slot_full ? '0 : slot + 1'b1;
        if (slot_full || last_pix) begin
          wea_r  <= 1'b1;
          dina_r <= word_nxt;
          pack_r <= '0;
        end else begin
          pack_r <= word_nxt;
        end
      end
      if (fire) begin
        sidx <= sidx + 32'd1;
        if (!is_hdr) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign S_AXIS_TREADY      = rdy_ok & ((state == S_IDLE) | (state == S_COLLECT));
  assign CHNL_TX            = tx_active;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_OFF        = '0;
  assign CHNL_TX_LEN        = tx_active ? 32'(len_words * WPB) : 32'd0;
  assign CHNL_TX_DATA_VALID = (state == S_SEND);
  assign CHNL_TX_DATA       = (state == S_SEND) ? (is_hdr ? hdr_word : doutb) : '0;
  assign tx_done            = fire & (sidx == last_idx);

  assign clka  = clk;
  assign addra = addra_r;
  assign dina  = dina_r;
  assign wea   = wea_r;

  // Prefetch word 0 in PREP; afterwards each accepted payload word fetches the next.
  assign clkb  = clk;
  assign enb   = (state == S_PREP) | (fire & ~is_hdr);
  assign addrb = (state == S_SEND) ? rd_ptr + 1'b1 : '0;

endmodule

// File: tb/tb_axis_to_riffa_tx.sv
// Directed testbench for axis_to_riffa_tx with a behavioural 1-cycle BRAM.
module tb_axis_to_riffa_tx;
  localparam int PW  = 128;
  localparam int AW  = 8;
  localparam int BAW = 12;
`ifdef AXIS2RIFFA_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    rows = '0, cols = '0;
  logic           tx_done;
  logic [AW-1:0]  tdata = '0;
  logic           tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic           S_AXIS_TREADY;
  logic           CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID;
  logic           ack = 1'b0, rdy = 1'b1;
  logic [31:0]    CHNL_TX_LEN;
  logic [30:0]    CHNL_TX_OFF;
  logic [PW-1:0]  CHNL_TX_DATA;
  logic [BAW-1:0] addra, addrb;
  logic           clka, clkb, wea, enb;
  logic [PW-1:0]  dina;
  logic [PW-1:0]  doutb = '0;
  logic [PW-1:0]  mem [0:(1<<BAW)-1];
  logic [PW-1:0]  rx_words [0:511];

  int n_cmp = 0;
  int n_fail = 0;

  axis_to_riffa_tx #(.PCIE_DATA_WIDTH(PW), .AXIS_DATA_WIDTH(AW), .BRAM_ADDR_WIDTH(BAW)) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .tx_done(tx_done),
    .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TUSER(tuser), .S_AXIS_TLAST(tlast),
    .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(ack), .CHNL_TX_LAST(CHNL_TX_LAST),
    .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF), .CHNL_TX_DATA(CHNL_TX_DATA),
    .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID), .CHNL_TX_DATA_READY(rdy),
    .addra(addra), .clka(clka), .dina(dina), .wea(wea),
    .addrb(addrb), .clkb(clkb), .doutb(doutb), .enb(enb)
  );

  always #5 clk = ~clk;

  // Simple-dual-port BRAM, read latency 1, output holds while enb is low.
  always @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (enb) doutb <= mem[addrb];
  end

  // Stimulus: optional stray beats, optional zero-size TUSER beats, then an r x c frame.
  task automatic drive_frame(input int r, input int c, input int ofs, input int nstray,
                             input int nzero, output bit ok);
    int n;
    n = r * c;
    ok = 1'b1;
    for (int i = 0; i < nstray; i++) begin
      @(negedge clk);
      rows = r; cols = c; tvalid = 1'b1; tuser = 1'b0; tlast = 1'b0; tdata = 8'hA5;
      #1; if (!S_AXIS_TREADY) ok = 1'b0;
    end
    for (int i = 0; i < nzero; i++) begin
      @(negedge clk);
      rows = 0; cols = c; tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0; tdata = 8'h5A;
      #1; if (!S_AXIS_TREADY) ok = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rows = r; cols = c; tvalid = 1'b1; tuser = (k == 0);
      tlast = ((k % c) == c - 1); tdata = AW'(k + ofs);
      #1; if (!S_AXIS_TREADY) ok = 1'b0;
    end
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    #1;
  endtask

  // Host side: waits for CHNL_TX, ACKs after ack_dly cycles, records words (no checking).
  task automatic collect_tx(input int ack_dly, input bit rnd, output int nw, output int len,
                            output int vdly, output int bubbles, output int unstable,
                            output int dones, output bit tmo, output bit tx_after);
    int cyc;
    bit stalled, fin;
    logic [PW-1:0] held;
    nw = 0; len = 0; vdly = 0; bubbles = 0; unstable = 0; dones = 0; tmo = 1'b0;
    tx_after = 1'b1; held = '0; stalled = 1'b0; fin = 1'b0;
    cyc = 0;
    while (!CHNL_TX && cyc < 200) begin @(negedge clk); #1; cyc++; end
    if (!CHNL_TX) begin tmo = 1'b1; return; end
    len = CHNL_TX_LEN;
    repeat (ack_dly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1; vdly = 1; cyc = 0;
    while (!CHNL_TX_DATA_VALID && cyc < 50) begin @(negedge clk); #1; vdly++; cyc++; end
    if (!CHNL_TX_DATA_VALID) begin tmo = 1'b1; return; end
    cyc = 0;
    while (!fin && cyc < 5000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled && CHNL_TX_DATA !== held) unstable++;
      if (!CHNL_TX_DATA_VALID) bubbles++;
      else if (rdy) begin
        rx_words[nw] = CHNL_TX_DATA;
        nw++;
        stalled = 1'b0;
        if (tx_done) begin dones++; fin = 1'b1; end
      end else begin
        stalled = 1'b1; held = CHNL_TX_DATA;
        if (tx_done) dones++;
      end
      @(negedge clk);
      cyc++;
    end
    rdy = 1'b1;
    #1;
    if (!fin) tmo = 1'b1;
    tx_after = CHNL_TX;
    if (tx_done) dones++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (S_AXIS_TREADY !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", S_AXIS_TREADY); end
    n_cmp++; if ({CHNL_TX, CHNL_TX_DATA_VALID, wea, enb, tx_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {CHNL_TX, CHNL_TX_DATA_VALID, wea, enb, tx_done}); end
    n_cmp++; if (CHNL_TX_LEN !== 32'd0 || CHNL_TX_DATA !== '0 || addra !== '0 || addrb !== '0 || dina !== '0) begin
      n_fail++; $display("FAIL reset_data: len=%0d addra=%0d addrb=%0d want all 0", CHNL_TX_LEN, addra, addrb); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (S_AXIS_TREADY !== 1'b0) begin n_fail++; $display("FAIL release_tready_early: got %b want 0", S_AXIS_TREADY); end
    @(negedge clk); #1;
    n_cmp++; if (S_AXIS_TREADY !== 1'b1) begin n_fail++; $display("FAIL release_tready: got %b want 1", S_AXIS_TREADY); end
  endtask

  task automatic test_full_word();
    bit ok, tmo, txa;
    int nw, len, vd, bub, uns, dn;
    logic [PW-1:0] exp_w;
    exp_w = 128'h0F0E0D0C0B0A09080706050403020100;
    drive_frame(4, 4, 0, 0, 0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL f4_tready: got stall want none"); end
    n_cmp++; if ({wea, CHNL_TX} !== 2'b11) begin n_fail++; $display("FAIL f4_c1: wea,tx=%b want 11", {wea, CHNL_TX}); end
    n_cmp++; if (dina !== exp_w || addra !== '0) begin n_fail++; $display("FAIL f4_dina: got %h@%0d want %h@0", dina, addra, exp_w); end
    collect_tx(0, 1'b0, nw, len, vd, bub, uns, dn, tmo, txa);
    n_cmp++; if (tmo) begin n_fail++; $display("FAIL f4_timeout: got timeout want completion"); end
    n_cmp++; if (len !== (1 + H) * 4) begin n_fail++; $display("FAIL f4_len: got %0d want %0d", len, (1 + H) * 4); end
    n_cmp++; if (nw !== 1 + H) begin n_fail++; $display("FAIL f4_nwords: got %0d want %0d", nw, 1 + H); end
    n_cmp++; if (rx_words[H] !== exp_w) begin n_fail++; $display("FAIL f4_payload: got %h want %h", rx_words[H], exp_w); end
`ifdef AXIS2RIFFA_HEADER_EN
    n_cmp++; if (rx_words[0] !== {64'b0, 32'd4, 32'd4}) begin n_fail++; $display("FAIL f4_header: got %h", rx_words[0]); end
`endif
    n_cmp++; if (vd !== 2) begin n_fail++; $display("FAIL f4_ack_to_valid: got %0d want 2", vd); end
    n_cmp++; if (dn !== 1 || txa !== 1'b0) begin n_fail++; $display("FAIL f4_done: pulses=%0d tx_after=%b want 1,0", dn, txa); end
  endtask

  task automatic test_partial_word();
    bit ok, tmo, txa;
    int nw, len, vd, bub, uns, dn;
    logic [PW-1:0] exp_w;
    exp_w = 128'h000F0E0D0C0B0A090807060504030201;
    drive_frame(3, 5, 1, 0, 0, ok);
    n_cmp++; if ({wea, CHNL_TX} !== 2'b10) begin n_fail++; $display("FAIL p35_c1: wea,tx=%b want 10", {wea, CHNL_TX}); end
    n_cmp++; if (dina !== exp_w) begin n_fail++; $display("FAIL p35_dina: got %h want %h", dina, exp_w); end
    @(negedge clk); #1;
    n_cmp++; if (CHNL_TX !== 1'b1) begin n_fail++; $display("FAIL p35_c2_tx: got %b want 1", CHNL_TX); end
    collect_tx(0, 1'b0, nw, len, vd, bub, uns, dn, tmo, txa);
    n_cmp++; if (tmo || nw !== 1 + H) begin n_fail++; $display("FAIL p35_words: got %0d tmo=%b want %0d", nw, tmo, 1 + H); end
    n_cmp++; if (len !== (1 + H) * 4) begin n_fail++; $display("FAIL p35_len: got %0d want %0d", len, (1 + H) * 4); end
    n_cmp++; if (rx_words[H] !== exp_w) begin n_fail++; $display("FAIL p35_payload: got %h want %h", rx_words[H], exp_w); end
  endtask

  task automatic test_stray_then_frame();
    bit ok, tmo, txa;
    int nw, len, vd, bub, uns, dn;
    logic [PW-1:0] w0, w1;
    w0 = 128'h0F0E0D0C0B0A09080706050403020100;
    w1 = 128'h1F1E1D1C1B1A19181716151413121110;
    drive_frame(4, 8, 0, 3, 1, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL s48_tready: got stall want none"); end
    collect_tx(0, 1'b0, nw, len, vd, bub, uns, dn, tmo, txa);
    n_cmp++; if (tmo || nw !== 2 + H) begin n_fail++; $display("FAIL s48_words: got %0d tmo=%b want %0d", nw, tmo, 2 + H); end
    n_cmp++; if (len !== (2 + H) * 4) begin n_fail++; $display("FAIL s48_len: got %0d want %0d", len, (2 + H) * 4); end
    n_cmp++; if (rx_words[H] !== w0 || rx_words[H+1] !== w1) begin
      n_fail++; $display("FAIL s48_payload: got %h %h want %h %h", rx_words[H], rx_words[H+1], w0, w1); end
    n_cmp++; if (bub !== 0) begin n_fail++; $display("FAIL s48_bubbles: got %0d want 0", bub); end
  endtask

  task automatic test_stall_large();
    bit ok, tmo, txa;
    int nw, len, vd, bub, uns, dn;
    logic [PW-1:0] exp_w;
    drive_frame(64, 64, 0, 0, 0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL big_tready: got stall want none"); end
    collect_tx(10, 1'b1, nw, len, vd, bub, uns, dn, tmo, txa);
    n_cmp++; if (tmo || nw !== 256 + H) begin n_fail++; $display("FAIL big_words: got %0d tmo=%b want %0d", nw, tmo, 256 + H); end
    n_cmp++; if (len !== (256 + H) * 4) begin n_fail++; $display("FAIL big_len: got %0d want %0d", len, (256 + H) * 4); end
    n_cmp++; if (uns !== 0) begin n_fail++; $display("FAIL big_stable: got %0d changes while stalled want 0", uns); end
    n_cmp++; if (vd !== 2 || dn !== 1) begin n_fail++; $display("FAIL big_timing: vdly=%0d done=%0d want 2,1", vd, dn); end
    for (int j = 0; j < 256; j++) begin
      for (int b = 0; b < 16; b++) exp_w[b*8 +: 8] = 8'((16 * j + b) & 255);
      n_cmp++;
      if (rx_words[H+j] !== exp_w) begin
        n_fail++; $display("FAIL big_word%0d: got %h want %h", j, rx_words[H+j], exp_w);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    bit ok, tmo, txa;
    int nw, len, vd, bub, uns, dn, cyc;
    logic [PW-1:0] exp_w;
    exp_w = 128'h2F2E2D2C2B2A29282726252423222120;
    rdy = 1'b0;
    drive_frame(4, 8, 8'h40, 0, 0, ok);
    cyc = 0;
    while (!CHNL_TX && cyc < 50) begin @(negedge clk); #1; cyc++; end
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    cyc = 0; #1;
    while (!CHNL_TX_DATA_VALID && cyc < 50) begin @(negedge clk); #1; cyc++; end
    n_cmp++; if (CHNL_TX_DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL rms_reach_send: got %b want 1", CHNL_TX_DATA_VALID); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({CHNL_TX, CHNL_TX_DATA_VALID, S_AXIS_TREADY} !== 3'b000) begin
      n_fail++; $display("FAIL rms_abort: tx,valid,tready=%b want 000", {CHNL_TX, CHNL_TX_DATA_VALID, S_AXIS_TREADY}); end
    rst = 1'b0; rdy = 1'b1;
    @(negedge clk);
    drive_frame(4, 4, 8'h20, 0, 0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rms_tready: got stall want none"); end
    collect_tx(0, 1'b0, nw, len, vd, bub, uns, dn, tmo, txa);
    n_cmp++; if (tmo || nw !== 1 + H) begin n_fail++; $display("FAIL rms_words: got %0d tmo=%b want %0d", nw, tmo, 1 + H); end
    n_cmp++; if (len !== (1 + H) * 4) begin n_fail++; $display("FAIL rms_len: got %0d want %0d", len, (1 + H) * 4); end
    n_cmp++; if (rx_words[H] !== exp_w) begin n_fail++; $display("FAIL rms_payload: got %h want %h", rx_words[H], exp_w); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_stray_then_frame();
    test_stall_large();
    test_reset_mid_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_to_riffa_tx.md
# axis_to_riffa_tx

Buffers one image frame arriving on an AXI4-Stream slave (one pixel per beat) into an external simple-dual-port BRAM. Pixels are packed into PCIe-width words. Once the frame is complete, the block returns it to the host as a single RIFFA TX transaction. It sits downstream of the image-processing core (e.g. rotate) and is the host-bound counterpart of the RIFFA-RX-to-AXIS front end.

## Interface
- `PCIE_DATA_WIDTH`, 128: RIFFA data and BRAM word width; must be a multiple of `AXIS_DATA_WIDTH` and ≥64.
- `AXIS_DATA_WIDTH`, 8: pixel width; PPW = `PCIE_DATA_WIDTH`/`AXIS_DATA_WIDTH` pixels per word.
- `BRAM_ADDR_WIDTH`, 12: BRAM word address width; capacity 2^`BRAM_ADDR_WIDTH` words.
- `clk` in 1: single clock; `clka`/`clkb` are driven from it.
- `rst` in 1: reset, synchronous, active-high.
- `rows`, `cols` in 32 each: output frame dimensions, sampled at frame start.
- `tx_done` out 1: one-cycle pulse when the last TX word is accepted.
- `S_AXIS_TDATA` in `AXIS_DATA_WIDTH`: pixel data.
- `S_AXIS_TVALID` in 1: pixel valid.
- `S_AXIS_TREADY` out 1: pixel ready.
- `S_AXIS_TUSER` in 1: start of frame.
- `S_AXIS_TLAST` in 1: end of line; ignored.
- `CHNL_TX` out 1: transaction request.
- `CHNL_TX_ACK` in 1: host acknowledge.
- `CHNL_TX_LAST` out 1: constant 1.
- `CHNL_TX_LEN` out 32: transfer length in 32-bit words.
- `CHNL_TX_OFF` out 31: constant 0.
- `CHNL_TX_DATA` out `PCIE_DATA_WIDTH`: TX data.
- `CHNL_TX_DATA_VALID` out 1: TX data valid.
- `CHNL_TX_DATA_READY` in 1: TX data ready.
- `addra` out `BRAM_ADDR_WIDTH`, `clka` out 1, `dina` out `PCIE_DATA_WIDTH`, `wea` out 1: BRAM write port.
- `addrb` out `BRAM_ADDR_WIDTH`, `clkb` out 1, `doutb` in `PCIE_DATA_WIDTH`, `enb` out 1: BRAM read port; read latency 1; `doutb` holds while `enb`=0.

## Operation
- Definitions: N = `rows`×`cols` (32-bit, truncated); W = ceil(N/PPW); H = 1 if header compiled in, else 0; T = W+H.
- IDLE: `S_AXIS_TREADY`=1. Beats without TUSER are accepted and discarded. A TUSER beat latches `rows`/`cols`; if N=0 the beat is dropped and the state stays IDLE. Otherwise the beat becomes pixel 0 and the state moves to COLLECT.
- COLLECT: `S_AXIS_TREADY`=1. Pixel k is packed little-endian: pixel k occupies slice [(k mod PPW)·AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]. When a word fills, `wea`=1 for one cycle with `dina`=packed word; `addra` then increments.
  - When pixel N−1 is accepted: if the word is partial, the unused slices are zero and it is written. The state moves to REQ.
  - A TUSER beat inside COLLECT is treated as ordinary data.
- REQ: `S_AXIS_TREADY`=0; `CHNL_TX`=1, `CHNL_TX_LEN`=T·`PCIE_DATA_WIDTH`/32. On `CHNL_TX_ACK` → PREP.
- PREP: one cycle; `enb`=1 with `addrb`=0 (prefetch). → SEND.
- SEND: `CHNL_TX_DATA_VALID`=1 continuously; `CHNL_TX` stays 1.
  - `CHNL_TX_DATA` = header word for index 0 when H=1, otherwise `doutb`.
  - On each VALID&READY, `enb`=1 and `addrb` advances to the next payload word, giving zero-bubble throughput. `enb` does not advance on the header word, because the prefetch is already correct.
  - On acceptance of word T−1: `tx_done` pulses and the state returns to IDLE; `CHNL_TX` is low the next cycle.
- `addra` and `addrb` are cleared to 0 on entering IDLE. Addresses wrap modulo depth; frames with W > 2^`BRAM_ADDR_WIDTH` are unsupported.

## Timing
- Reset values: state IDLE, all outputs 0 (`S_AXIS_TREADY` is 1 one cycle after reset release), latched rows/cols = 0. Reset mid-frame or mid-send aborts immediately with no partial TX.
- Last pixel accepted at cycle c: final `wea` at c+1, `CHNL_TX` at c+1 (or c+2 when a partial flush is needed).
- ACK at cycle a: PREP at a+1, first VALID at a+2.
- READY low stalls `CHNL_TX_DATA`, which holds its value.
- ACK arriving in the same cycle `CHNL_TX` first rises is accepted.

## Configuration
- `AXIS2RIFFA_HEADER_EN` defined: H=1. TX word 0 = {zero pad, cols[31:0], rows[31:0]}, with rows in bits [31:0]. Payload follows from BRAM word 0.
- Not defined: H=0, and the transfer is payload only.

## Test plan
- 4×4 frame, pixels 0x00..0x0F, READY=1, no header → `CHNL_TX_LEN`=4, one word 0x0F0E…0100, `tx_done` pulse.
- Same frame with `AXIS2RIFFA_HEADER_EN` → LEN=8, word0={64'b0,32'd4,32'd4}, word1 = payload.
- 3×5 frame, pixels 1..15 → LEN=4, bits [127:120]=0x00, bits [119:112]=0x0F.
- 3 beats without TUSER, then a 4×8 TUSER frame → stray beats discarded, LEN=8, two words, zero bubbles with READY=1.
- 64×64 frame with `CHNL_TX_DATA_READY` toggling randomly → all 256 words in order, DATA stable while stalled, ACK delayed 10 cycles tolerated.
- `rst` asserted mid-SEND, then a new 4×4 frame → `CHNL_TX`=0 the next cycle, new frame correct, LEN=4.
